scancode_decoder: RTL and testbench

SCANCODE_DECODER -- requirements
Module: scancode_decoder

---
 rtl/scancode_decoder_pkg.sv | 56 +++++
 rtl/scancode_decoder_key.sv | 60 ++++++
 rtl/scancode_decoder.sv | 111 +++++++++++
 tb/tb_scancode_decoder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scancode_decoder_pkg.sv
// Shared types and code tables for the PS/2 keypad scancode decoder.
// Holds the prefix FSM encoding, prefix/shift codes and the make-code map.
package scancode_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } state_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  localparam logic [7:0] KEY_HASH  = 8'h0A;
  localparam logic [7:0] KEY_STAR  = 8'h0B;
  localparam logic [7:0] KEY_CLR   = 8'h0C;

  typedef struct packed {
    logic       hit;
    logic [7:0] key;
  } key_hit_t;

  function automatic logic is_shift(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

  function automatic key_hit_t map_make(
    input logic [7:0] code,
    input logic       shift
  );
    key_hit_t r;
    r.hit = 1'b1;
    r.key = 8'h00;
    case (code)
      8'h45:   r.key = 8'h00;
      8'h16:   r.key = 8'h01;
      8'h1E:   r.key = 8'h02;
      8'h26:   r.key = shift ? KEY_HASH : 8'h03;
      8'h25:   r.key = 8'h04;
      8'h2E:   r.key = 8'h05;
      8'h36:   r.key = 8'h06;
      8'h3D:   r.key = 8'h07;
      8'h3E:   r.key = shift ? KEY_STAR : 8'h08;
      8'h46:   r.key = 8'h09;
      8'h29:   r.key = KEY_CLR;
      default: r.hit = 1'b0;
    endcase
    // Shifted digits other than '#' and '*' produce nothing.
    if (shift && r.key <= 8'h09) r.hit = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/scancode_decoder_key.sv
// Show-ahead decoded-key FIFO with sticky overflow flag.
// A pop and push on the same edge pop first, so a full FIFO can accept.
module key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       vld_o,
  output logic       ovf_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, pop, push_ok;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == FULL_CNT);
    pop     = pop_i && !empty;
    push_ok = push_i && (!full || pop);
    rd_d    = rd_q + AW'(pop);
    wr_d    = wr_q + AW'(push_ok);
    cnt_d   = cnt_q + CW'(push_ok) - CW'(pop);
    ovf_d   = ovf_q || (push_i && !push_ok);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

  assign data_o = empty ? 8'h00 : mem_q[rd_q];
  assign vld_o  = !empty;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/scancode_decoder.sv
// PS/2 keypad scancode decoder: frame check, prefix FSM, shift,
// typematic suppression and a show-ahead key FIFO.
module scancode_decoder
  import scancode_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        iCLK_50,
  input  logic        iRST,
  input  logic [10:0] iFRAME,
  input  logic        iFRAME_VLD,
  input  logic        iKEY_RD,
  output logic [7:0]  oKEY,
  output logic        oKEY_VLD,
  output logic        oSHIFT,
  output logic        oERR,
  output logic        oOVF
);

  state_e     state_q, state_d;
  logic       shift_q, shift_d;
  logic [7:0] held_q, held_d;
  logic       err_q, err_d;
  logic       push_q, push_d;
  logic [7:0] pkey_q, pkey_d;
  logic [7:0] data;
  logic       frame_ok;
  key_hit_t   lk;

  always_comb begin
    data     = iFRAME[8:1];
    frame_ok = !iFRAME[0] && iFRAME[10] && (^iFRAME[9:1]);
    lk       = map_make(data, shift_q);
    state_d  = state_q;
    shift_d  = shift_q;
    held_d   = held_q;
    err_d    = 1'b0;
    push_d   = 1'b0;
    pkey_d   = 8'h00;
    if (iFRAME_VLD) begin
      if (!frame_ok) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (data == SC_BRK) begin
              state_d = ST_BRK;
            end else if (data == SC_EXT) begin
              state_d = ST_EXT;
            end else if (data != held_q) begin
              held_d = data;
              if (is_shift(data)) begin
                shift_d = 1'b1;
              end else if (lk.hit) begin
                push_d = 1'b1;
                pkey_d = lk.key;
              end
            end
          end
          ST_BRK: begin
            state_d = ST_IDLE;
            if (is_shift(data)) shift_d = 1'b0;
            if (data == held_q) held_d = 8'h00;
          end
          ST_EXT: begin
            state_d = (data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
          end
          ST_EXT_BRK: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      shift_q <= 1'b0;
      held_q  <= 8'h00;
      err_q   <= 1'b0;
      push_q  <= 1'b0;
      pkey_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      held_q  <= held_d;
      err_q   <= err_d;
      push_q  <= push_d;
      pkey_q  <= pkey_d;
    end
  end

  key_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (iCLK_50),
    .rst_i  (iRST),
    .push_i (push_q),
    .data_i (pkey_q),
    .pop_i  (iKEY_RD),
    .data_o (oKEY),
    .vld_o  (oKEY_VLD),
    .ovf_o  (oOVF)
  );

  assign oSHIFT = shift_q;
  assign oERR   = err_q;

endmodule

// File: tb/tb_scancode_decoder.sv
// Directed bench for scancode_decoder with a queue-based reference model.
module tb_scancode_decoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] frame;
  logic        fvld;
  logic        rd;
  logic [7:0]  key;
  logic        kvld, shift, err, ovf;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .iCLK_50    (clk),
    .iRST       (rst),
    .iFRAME     (frame),
    .iFRAME_VLD (fvld),
    .iKEY_RD    (rd),
    .oKEY       (key),
    .oKEY_VLD   (kvld),
    .oSHIFT     (shift),
    .oERR       (err),
    .oOVF       (ovf)
  );

  always #10 clk = ~clk;

  // Reference model
  logic [7:0] mq[$];
  bit         m_shift, m_err, m_ovf, m_brk, m_ext, m_pend;
  logic [7:0] m_held, m_pkey;
  logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                              8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  task automatic model_byte(input logic [7:0] d);
    int idx;
    if (m_ext) begin
      if (!m_brk && d == 8'hF0) m_brk = 1;
      else begin m_ext = 0; m_brk = 0; end
    end else if (m_brk) begin
      m_brk = 0;
      if (d == 8'h12 || d == 8'h59) m_shift = 0;
      if (d == m_held) m_held = 8'h00;
    end else if (d == 8'hF0) begin
      m_brk = 1;
    end else if (d == 8'hE0) begin
      m_ext = 1;
    end else if (d != m_held) begin
      m_held = d;
      if (d == 8'h12 || d == 8'h59) m_shift = 1;
      else begin
        idx = -1;
        for (int i = 0; i < 10; i++) if (digits[i] == d) idx = i;
        if (d == 8'h29) begin m_pend = 1; m_pkey = 8'h0C; end
        else if (idx >= 0 && !m_shift) begin
          m_pend = 1; m_pkey = 8'(idx);
        end else if (idx == 3 && m_shift) begin
          m_pend = 1; m_pkey = 8'h0A;
        end else if (idx == 8 && m_shift) begin
          m_pend = 1; m_pkey = 8'h0B;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_shift = 0; m_err = 0; m_ovf = 0; m_brk = 0; m_ext = 0;
      m_pend = 0; m_held = 8'h00; m_pkey = 8'h00;
    end else begin
      if (rd && mq.size() > 0) void'(mq.pop_front());
      if (m_pend) begin
        if (mq.size() < DEPTH) mq.push_back(m_pkey);
        else m_ovf = 1;
      end
      m_pend = 0;
      m_err  = 0;
      if (fvld) begin
        if (frame[0] || !frame[10] || !(^frame[9:1])) begin
          m_err = 1; m_brk = 0; m_ext = 0;
        end else model_byte(frame[8:1]);
      end
    end
  end

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_kvld", {7'b0, kvld}, {7'b0, mq.size() != 0});
      if (mq.size() != 0) check("m_key", key, mq[0]);
      check("m_shift", {7'b0, shift}, {7'b0, m_shift});
      check("m_err", {7'b0, err}, {7'b0, m_err});
      check("m_ovf", {7'b0, ovf}, {7'b0, m_ovf});
    end
  end

  function automatic logic [10:0] mk(input logic [7:0] d, input bit good);
    logic p;
    p = ~^d;
    if (!good) p = ~p;
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic send(input logic [7:0] d, input bit good = 1);
    frame = mk(d, good);
    fvld  = 1;
    @(negedge clk);
    fvld  = 0;
  endtask

  task automatic pop_one();
    rd = 1;
    @(negedge clk);
    rd = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1; frame = '0; fvld = 0; rd = 0;
    idle(2);
    rst = 0;
    chk_en = 1;
    check("rst_key", key, 8'h00);
    check("rst_kvld", {7'b0, kvld}, 8'h00);
    check("rst_shift", {7'b0, shift}, 8'h00);
    check("rst_ovf", {7'b0, ovf}, 8'h00);

    // Single key, two-edge latency, then pop
    send(8'h16);
    check("lat1_kvld", {7'b0, kvld}, 8'h00);
    idle(1);
    check("lat2_kvld", {7'b0, kvld}, 8'h01);
    check("lat2_key", key, 8'h01);
    pop_one();
    check("pop_kvld", {7'b0, kvld}, 8'h00);

    // Shift: 12, 26, F0 26, F0 12, 26
    send(8'h12);
    check("shift_on", {7'b0, shift}, 8'h01);
    send(8'h26); send(8'hF0); send(8'h26); send(8'hF0); send(8'h12);
    check("shift_off", {7'b0, shift}, 8'h00);
    send(8'h26);
    idle(2);
    check("shift_k0", key, 8'h0A);
    pop_one();
    check("shift_k1", key, 8'h03);
    pop_one();
    check("shift_empty", {7'b0, kvld}, 8'h00);

    // Parity error then valid frame
    send(8'h45, 0);
    check("err_pulse", {7'b0, err}, 8'h01);
    idle(1);
    check("err_clear", {7'b0, err}, 8'h00);
    check("err_nokey", {7'b0, kvld}, 8'h00);
    send(8'h45);
    idle(1);
    check("err_next", key, 8'h00);
    check("err_next_v", {7'b0, kvld}, 8'h01);
    pop_one();

    // Framing error (start bit high) resets pending prefix
    send(8'hF0);
    frame = mk(8'h25, 1) | 11'h001; fvld = 1; @(negedge clk); fvld = 0;
    check("frm_err", {7'b0, err}, 8'h01);
    send(8'h25);
    idle(1);
    check("frm_key", key, 8'h04);
    pop_one();

    // Typematic suppression
    do_reset();
    send(8'h1E); send(8'h1E); send(8'h1E);
    send(8'hF0); send(8'h1E); send(8'h1E);
    idle(2);
    check("typ_k0", key, 8'h02);
    pop_one();
    check("typ_k1", key, 8'h02);
    pop_one();
    check("typ_empty", {7'b0, kvld}, 8'h00);

    // Overflow: five keys, no pop
    do_reset();
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
    idle(2);
    check("ovf_set", {7'b0, ovf}, 8'h01);
    for (int i = 1; i <= 4; i++) begin
      check("ovf_keep", key, 8'(i));
      pop_one();
    end
    check("ovf_empty", {7'b0, kvld}, 8'h00);

    // Full FIFO: push coincides with pop
    do_reset();
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
    idle(2);
    frame = mk(8'h2E, 1); fvld = 1;
    @(negedge clk);
    fvld = 0; rd = 1;
    @(negedge clk);
    rd = 0;
    check("full_noovf", {7'b0, ovf}, 8'h00);
    for (int i = 2; i <= 5; i++) begin
      check("full_keep", key, 8'(i));
      pop_one();
    end

    // Extended code, then reset mid-prefix
    do_reset();
    send(8'hE0); send(8'h75); send(8'hF0);
    idle(2);
    check("ext_nokey", {7'b0, kvld}, 8'h00);
    do_reset();
    send(8'h16);
    idle(1);
    check("rstmid_key", key, 8'h01);
    check("rstmid_v", {7'b0, kvld}, 8'h01);
    pop_one();

    // Space maps to clear, shifted space too; shifted 0x3E -> '*'
    send(8'h29); send(8'h59); send(8'h3E); send(8'h16);
    idle(2);
    check("space", key, 8'h0C);
    pop_one();
    check("star", key, 8'h0B);
    pop_one();
    check("shift_dig_ign", {7'b0, kvld}, 8'h00);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
